pipeline_rx_buffer: RTL and testbench
=====================================

# pipeline_rx_buffer

Receive-side capture buffer for the 16-bit valid-only pipeline output stream. It accepts one word per cycle whenever the producer asserts valid. The producer has no backpressure, so the block holds words in a small FIFO and presents them to the consumer over a ready/valid handshake. Overflow is flagged and counted rather than stalling the pipeline, because the pipeline cannot stall.

## Interface
Parameters:
- DATA_W, 16, width of the data word
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 8, width of the drop counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock domain
- in_data  input  DATA_W  word from the pipeline output stage
- in_valid  input  1  in_data is valid this cycle; no ready is returned
- out_data  output  DATA_W  head-of-FIFO word
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data this cycle
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: at least one word dropped since the last clear
- drop_count  output  CNT_W  number of dropped words, saturating at 2^CNT_W−1
- stat_clr  input  1  synchronous clear of overflow and drop_count

## Operation
- Storage: DEPTH-entry register array with rd_ptr and wr_ptr, each log2(DEPTH)+1 bits.
  - Pointer MSB distinguishes full from empty; pointers wrap modulo 2·DEPTH.
- empty = (rd_ptr == wr_ptr).
- full = low bits equal and MSBs differ.
- level = wr_ptr − rd_ptr, modulo 2·DEPTH.
- The output is first-word fall-through:
  - out_data = mem[rd_ptr low bits].
  - out_valid = !empty.
  - out_data is don't-care when out_valid=0; the bench must not check it then.
- pop = out_valid & out_ready. It advances rd_ptr. out_ready while empty has no effect.
- push = in_valid & (!full | pop). It writes mem[wr_ptr] and advances wr_ptr.
  - Full with a simultaneous pop: the write is accepted and level stays DEPTH.
- drop = in_valid & full & !pop. The word is discarded and the FIFO is unchanged.
- On drop:
  - overflow←1.
  - drop_count←drop_count+1, saturating at all-ones (no wrap).
- On stat_clr:
  - overflow←0 and drop_count←0.
  - If drop is also asserted in the same cycle, the new event is recorded: overflow←1, drop_count←1.
- Push and pop together, not full and not empty: both pointers advance and level is unchanged.
- Word order is preserved strictly FIFO. No word is duplicated. A word is lost only via drop.

## Timing
- Reset (rst_n=0, asynchronous assert) sets:
  - rd_ptr=wr_ptr=0.
  - out_valid=0, level=0, overflow=0, drop_count=0.
  - Stored data is not reset.
- Reset asserted mid-operation discards all held words immediately. No pop is reported for them.
- Deassertion is synchronous to clk (synchronized upstream). The first push can occur on the first edge after release.
- Latency from in_valid to out_valid is 1 cycle. A word presented at edge N appears on out_data/out_valid after edge N; the FIFO was empty.
- Pops at a steady rate of 1 word/cycle sustain full throughput with level constant.
- level, overflow and drop_count are registered; each updates on the edge where the event occurs.
- out_data changes only on a pop or on a push into an empty FIFO.

## Test plan
- Fill/drain: consumer holds out_ready=0. Push 0x0001..0x0004 on consecutive cycles → level=4, out_valid=1, out_data=0x0001. Then hold out_ready=1 for 4 cycles → outputs 0x0001..0x0004 in order, level=0, out_valid=0, overflow=0.
- Overflow: out_ready=0 with the FIFO full (4 words). Push 3 more words → FIFO contents unchanged, overflow=1, drop_count=3. Then pulse stat_clr → overflow=0, drop_count=0.
- Full + simultaneous pop: FIFO full with 0xA0..0xA3. In the same cycle, in_valid with 0xA4 and out_ready=1 → no drop, level=4. Subsequent drain yields 0xA1,0xA2,0xA3,0xA4.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 cycles, data 0..19 → out_data lags in_data by exactly 1 cycle, level=1 throughout, no drops. Pointers wrap at least twice.
- Saturation and clear collision: CNT_W=8. Force 300 drops → drop_count=255, held. Then assert stat_clr in the same cycle as one drop → overflow=1, drop_count=1.
- Reset mid-operation: with level=3 and overflow=1, assert rst_n=0 between edges → out_valid, level and overflow go to 0 immediately. After release, the first pushed word 0x5A5A is the first word popped.

Source files
------------

// File: rtl/pipeline_rx_buffer.sv
// ---------------------------------------------------------------------------
// pipeline_rx_buffer
//
// Receive-side capture buffer for a valid-only pipeline output stream. The
// producer cannot be stalled, so words are held in a small first-word
// fall-through FIFO and offered to the consumer over a ready/valid handshake.
// A word arriving while the FIFO is full (and not being drained that cycle)
// is discarded; the loss is recorded in a sticky overflow flag and a
// saturating drop counter.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     word from the pipeline output stage
//   in_valid    in_data valid this cycle (no backpressure)
//   out_data    head-of-FIFO word (meaningful only while out_valid=1)
//   out_valid   FIFO not empty
//   out_ready   consumer accepts out_data this cycle
//   level       current occupancy, 0..DEPTH
//   overflow    sticky: a word has been dropped since the last clear
//   drop_count  number of dropped words, saturating at all-ones
//   stat_clr    synchronous clear of overflow and drop_count
// ---------------------------------------------------------------------------
module pipeline_rx_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     stat_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + CNT_W'(1);
    end
    return res;
  endfunction

  // Storage and pointers. The extra pointer MSB separates full from empty.
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_next_s;
  logic [PW-1:0]     wr_ptr_next_s;

  logic              out_valid_r;
  logic [PW-1:0]     level_r;
  logic              overflow_r;
  logic [CNT_W-1:0]  drop_count_r;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;

  // Occupancy decode and handshake qualification.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    drop_s  = 1'b0;
    if (rd_ptr_r == wr_ptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if ((rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]) && (rd_ptr_r[AW] != wr_ptr_r[AW])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    pop_s  = !empty_s && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s = in_valid && (!full_s || pop_s);
    drop_s = in_valid && full_s && !pop_s;
  end

  // Next pointer values, shared by the pointer, level and valid registers.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
  end

  // Pointer, occupancy and valid registers; level wraps modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      level_r     <= {PW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      level_r     <= wr_ptr_next_s - rd_ptr_next_s;
      out_valid_r <= (wr_ptr_next_s != rd_ptr_next_s);
    end
  end

  // Data array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

  // Loss statistics. A clear coinciding with a drop keeps that new drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r   <= 1'b0;
      drop_count_r <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      overflow_r   <= drop_s;
      drop_count_r <= drop_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_r   <= 1'b1;
      drop_count_r <= sat_inc(drop_count_r);
    end else begin
      overflow_r   <= overflow_r;
      drop_count_r <= drop_count_r;
    end
  end

  // Fall-through head read straight from the register array.
  assign out_data   = mem_r[rd_ptr_r[AW-1:0]];
  assign out_valid  = out_valid_r;
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_pipeline_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_rx_buffer
//
// Directed self-checking bench for pipeline_rx_buffer (DATA_W=16, DEPTH=4,
// CNT_W=8). Inputs change 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_pipeline_rx_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        stat_clr;

  int n_checks;
  int n_fail;

  pipeline_rx_buffer #(.DATA_W(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .stat_clr   (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      step();
      check("fill_level", {29'd0, level}, 32'(i));
      check("fill_out_valid", {31'd0, out_valid}, 32'd1);
      check("fill_head", {16'd0, out_data}, 32'h0001);
    end
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", {16'd0, out_data}, 32'(i));
      step();
      check("drain_level", {29'd0, level}, 32'(4 - i));
    end
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_overflow", {31'd0, overflow}, 32'd0);
    out_ready = 1'b0;

    // Overflow: fill, then three drops
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0011 + i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0099;
      step();
      check("ovf_level", {29'd0, level}, 32'd4);
    end
    in_valid = 1'b0;
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop_count", {24'd0, drop_count}, 32'd3);
    check("ovf_head", {16'd0, out_data}, 32'h0011);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    check("clr_drop_count", {24'd0, drop_count}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_contents", {16'd0, out_data}, 32'(16'h0011 + i));
      step();
    end
    check("ovf_drained_level", {29'd0, level}, 32'd0);
    out_ready = 1'b0;

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h00A0 + i);
      step();
    end
    check("fp_level_full", {29'd0, level}, 32'd4);
    in_valid  = 1'b1;
    in_data   = 16'h00A4;
    out_ready = 1'b1;
    check("fp_head", {16'd0, out_data}, 32'h00A0);
    step();
    in_valid = 1'b0;
    check("fp_level", {29'd0, level}, 32'd4);
    check("fp_overflow", {31'd0, overflow}, 32'd0);
    check("fp_drop_count", {24'd0, drop_count}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("fp_drain", {16'd0, out_data}, 32'(16'h00A0 + i));
      step();
    end
    check("fp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: push and pop every cycle, pointers wrap repeatedly
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 16'(k);
      step();
      check("stream_level", {29'd0, level}, 32'd1);
      check("stream_data", {16'd0, out_data}, 32'(k));
    end
    in_valid = 1'b0;
    step();
    check("stream_end_level", {29'd0, level}, 32'd0);
    check("stream_drops", {24'd0, drop_count}, 32'd0);
    check("stream_overflow", {31'd0, overflow}, 32'd0);
    out_ready = 1'b0;

    // Saturation of the drop counter
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0100 + i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      step();
    end
    check("sat_drop_count", {24'd0, drop_count}, 32'd255);
    check("sat_overflow", {31'd0, overflow}, 32'd1);
    check("sat_level", {29'd0, level}, 32'd4);
    check("sat_head", {16'd0, out_data}, 32'h0100);
    // Clear colliding with a drop keeps the new drop
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    in_valid = 1'b0;
    check("coll_overflow", {31'd0, overflow}, 32'd1);
    check("coll_drop_count", {24'd0, drop_count}, 32'd1);

    // Reset mid-operation with level=3, overflow=1
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_rst_level", {29'd0, level}, 32'd3);
    check("pre_rst_overflow", {31'd0, overflow}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_level", {29'd0, level}, 32'd0);
    check("async_overflow", {31'd0, overflow}, 32'd0);
    check("async_drop_count", {24'd0, drop_count}, 32'd0);
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_level", {29'd0, level}, 32'd1);
    check("post_rst_data", {16'd0, out_data}, 32'h5A5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_rst_drained", {29'd0, level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
